product_alignment_sequencer: RTL and testbench

- Stage directly downstream of exponent comparison in the 9-term dot-product FMA datapath.
- Consumes the nine product significands and the addend significand, plus the per-term shift amounts and the common exponent produced upstream.
- Right-aligns every term to the maximum product exponent and generates a sticky bit per term.
- Uses one shared barrel shifter, time-multiplexed over 10 entries, under a valid/ready handshake. Output feeds the CSA adder tree.

---
 rtl/product_alignment_sequencer_if.sv | 49 ++++
 rtl/product_alignment_sequencer.sv | 176 +++++++++++++++++
 tb/tb_product_alignment_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/product_alignment_sequencer_if.sv
// Handshake/data bundle for product_alignment_sequencer.
//   master : upstream operand source plus downstream consumer (drives in_valid,
//            operands, out_ready; observes in_ready and aligned results)
//   slave  : the alignment sequencer itself
// Operand fields: prod_sig/prod_sign/shamt_ab (9 packed terms), c_sig/c_sign/
// shamt_c (addend), exp1 (result exponent).
// Result fields: aln_prod/sticky_prod (9 terms), aln_c/sticky_c, sign_out, exp_out.
interface product_alignment_sequencer_if #(
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned SHAMT_WIDTH = 9
);
  localparam int unsigned PROD_WIDTH = 2 * (SIG_WIDTH + 1);
  localparam int unsigned PALN_WIDTH = PROD_WIDTH + 2;
  localparam int unsigned CALN_WIDTH = 3 * SIG_WIDTH + 9;

  logic                     in_valid;
  logic                     in_ready;
  logic [9*PROD_WIDTH-1:0]  prod_sig;
  logic [8:0]               prod_sign;
  logic [9*SHAMT_WIDTH-1:0] shamt_ab;
  logic [SIG_WIDTH:0]       c_sig;
  logic                     c_sign;
  logic [SHAMT_WIDTH-1:0]   shamt_c;
  logic [EXP_WIDTH-1:0]     exp1;

  logic                     out_valid;
  logic                     out_ready;
  logic [9*PALN_WIDTH-1:0]  aln_prod;
  logic [8:0]               sticky_prod;
  logic [CALN_WIDTH-1:0]    aln_c;
  logic                     sticky_c;
  logic [9:0]               sign_out;
  logic [EXP_WIDTH-1:0]     exp_out;

  modport master (
    output in_valid, prod_sig, prod_sign, shamt_ab, c_sig, c_sign, shamt_c, exp1,
    output out_ready,
    input  in_ready, out_valid, aln_prod, sticky_prod, aln_c, sticky_c,
    input  sign_out, exp_out
  );

  modport slave (
    input  in_valid, prod_sig, prod_sign, shamt_ab, c_sig, c_sign, shamt_c, exp1,
    input  out_ready,
    output in_ready, out_valid, aln_prod, sticky_prod, aln_c, sticky_c,
    output sign_out, exp_out
  );
endinterface

// File: rtl/product_alignment_sequencer.sv
// Alignment stage of the 9-term dot-product FMA datapath. Right-shifts each of
// the nine product significands (with guard/round LSBs appended) and the addend
// significand by its per-term shift amount, producing a sticky bit per term.
// A single barrel shifter is reused over 10 cycles (products 0..8, then addend).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   io       : operand/result bundle (slave side), valid/ready on both ends
module product_alignment_sequencer #(
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned SHAMT_WIDTH = 9,
  parameter int unsigned PROD_WIDTH  = 2 * (SIG_WIDTH + 1),
  parameter int unsigned PALN_WIDTH  = PROD_WIDTH + 2,
  parameter int unsigned CALN_WIDTH  = 3 * SIG_WIDTH + 9
) (
  input  logic                            clk,
  input  logic                            rst,
  product_alignment_sequencer_if.slave    io
);
  localparam int unsigned NTERM    = 9;
  localparam logic [3:0]  LAST_IDX = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [3:0]               idx_q, idx_d;
  logic [9*PROD_WIDTH-1:0]  prod_q, prod_d;
  logic [9*SHAMT_WIDTH-1:0] shamt_ab_q, shamt_ab_d;
  logic [SIG_WIDTH:0]       c_q, c_d;
  logic [SHAMT_WIDTH-1:0]   shamt_c_q, shamt_c_d;

  logic                     out_valid_q, out_valid_d;
  logic [9*PALN_WIDTH-1:0]  aln_prod_q, aln_prod_d;
  logic [8:0]               sticky_prod_q, sticky_prod_d;
  logic [CALN_WIDTH-1:0]    aln_c_q, aln_c_d;
  logic                     sticky_c_q, sticky_c_d;
  logic [9:0]               sign_q, sign_d;
  logic [EXP_WIDTH-1:0]     exp_q, exp_d;

  logic in_ready, accept, shift_en, last_entry;

  logic [CALN_WIDTH-1:0]  sh_src, sh_res, sh_mask;
  logic [SHAMT_WIDTH-1:0] sh_amt;
  logic                   sh_sticky;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.in_valid) state_d = SHIFT;
      SHIFT:   if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (io.out_ready) state_d = io.in_valid ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = ~rst & ((state_q == IDLE) | ((state_q == DONE) & io.out_ready));
    accept     = io.in_valid & in_ready;
    shift_en   = (state_q == SHIFT);
    last_entry = shift_en & (idx_q == LAST_IDX);
  end

  // Shared shifter. Products sit zero-extended in the low PALN_WIDTH bits of the
  // CALN_WIDTH field, so one mask-based sticky covers both field widths and any
  // shift at or beyond the field width yields zero with sticky = OR of source.
  always_comb begin
    sh_src = '0;
    sh_amt = '0;
    if (idx_q == LAST_IDX) begin
      sh_src = {c_q, {(CALN_WIDTH - SIG_WIDTH - 1){1'b0}}};
      sh_amt = shamt_c_q;
    end else begin
      for (int unsigned i = 0; i < NTERM; i++) begin
        if (idx_q == 4'(i)) begin
          sh_src[PALN_WIDTH-1:0] = {prod_q[i*PROD_WIDTH +: PROD_WIDTH], 2'b00};
          sh_amt                 = shamt_ab_q[i*SHAMT_WIDTH +: SHAMT_WIDTH];
        end
      end
    end
    sh_res    = sh_src >> sh_amt;
    sh_mask   = ~({CALN_WIDTH{1'b1}} << sh_amt);
    sh_sticky = |(sh_src & sh_mask);
  end

  // Datapath next-state
  always_comb begin
    idx_d         = idx_q;
    prod_d        = prod_q;
    shamt_ab_d    = shamt_ab_q;
    c_d           = c_q;
    shamt_c_d     = shamt_c_q;
    out_valid_d   = out_valid_q;
    aln_prod_d    = aln_prod_q;
    sticky_prod_d = sticky_prod_q;
    aln_c_d       = aln_c_q;
    sticky_c_d    = sticky_c_q;
    sign_d        = sign_q;
    exp_d         = exp_q;

    if (accept) begin
      idx_d       = '0;
      prod_d      = io.prod_sig;
      shamt_ab_d  = io.shamt_ab;
      c_d         = io.c_sig;
      shamt_c_d   = io.shamt_c;
      sign_d      = {io.c_sign, io.prod_sign};
      exp_d       = io.exp1;
      out_valid_d = 1'b0;
    end else if ((state_q == DONE) && io.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (shift_en) begin
      idx_d = idx_q + 4'd1;
      for (int unsigned i = 0; i < NTERM; i++) begin
        if (idx_q == 4'(i)) begin
          aln_prod_d[i*PALN_WIDTH +: PALN_WIDTH] = sh_res[PALN_WIDTH-1:0];
          sticky_prod_d[i]                       = sh_sticky;
        end
      end
      if (last_entry) begin
        aln_c_d     = sh_res;
        sticky_c_d  = sh_sticky;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      prod_q        <= '0;
      shamt_ab_q    <= '0;
      c_q           <= '0;
      shamt_c_q     <= '0;
      out_valid_q   <= 1'b0;
      aln_prod_q    <= '0;
      sticky_prod_q <= '0;
      aln_c_q       <= '0;
      sticky_c_q    <= 1'b0;
      sign_q        <= '0;
      exp_q         <= '0;
    end else begin
      idx_q         <= idx_d;
      prod_q        <= prod_d;
      shamt_ab_q    <= shamt_ab_d;
      c_q           <= c_d;
      shamt_c_q     <= shamt_c_d;
      out_valid_q   <= out_valid_d;
      aln_prod_q    <= aln_prod_d;
      sticky_prod_q <= sticky_prod_d;
      aln_c_q       <= aln_c_d;
      sticky_c_q    <= sticky_c_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = out_valid_q;
  assign io.aln_prod    = aln_prod_q;
  assign io.sticky_prod = sticky_prod_q;
  assign io.aln_c       = aln_c_q;
  assign io.sticky_c    = sticky_c_q;
  assign io.sign_out    = sign_q;
  assign io.exp_out     = exp_q;
endmodule

// File: tb/tb_product_alignment_sequencer.sv
// Scoreboard bench for product_alignment_sequencer: expected aligned sets are
// computed from the operands at accept time and checked when out_valid rises.
module tb_product_alignment_sequencer;
  localparam int unsigned SW  = 23;
  localparam int unsigned EW  = 8;
  localparam int unsigned AW  = 9;
  localparam int unsigned PW  = 2 * (SW + 1);
  localparam int unsigned PA  = PW + 2;
  localparam int unsigned CA  = 3 * SW + 9;

  typedef struct {
    logic [9*PW-1:0] prod;
    logic [8:0]      psign;
    logic [9*AW-1:0] sab;
    logic [SW:0]     c;
    logic            csign;
    logic [AW-1:0]   sc;
    logic [EW-1:0]   e;
  } in_t;

  typedef struct {
    logic [9*PA-1:0] aln_prod;
    logic [8:0]      stp;
    logic [CA-1:0]   alnc;
    logic            stc;
    logic [9:0]      sign;
    logic [EW-1:0]   e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  product_alignment_sequencer_if #(.SIG_WIDTH(SW), .EXP_WIDTH(EW), .SHAMT_WIDTH(AW)) bus ();

  product_alignment_sequencer #(.SIG_WIDTH(SW), .EXP_WIDTH(EW), .SHAMT_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Bit-serial reference: each source bit either lands at b-amt or falls into sticky.
  function automatic exp_t model(input in_t s);
    exp_t r;
    logic [PA-1:0] ps, pr;
    logic [CA-1:0] cs, cr;
    int amt;
    r.stp = '0;
    r.aln_prod = '0;
    for (int i = 0; i < 9; i++) begin
      ps  = {s.prod[i*PW +: PW], 2'b00};
      pr  = '0;
      amt = int'(s.sab[i*AW +: AW]);
      for (int b = 0; b < int'(PA); b++) begin
        if (b < amt) r.stp[i] = r.stp[i] | ps[b];
        else         pr[b-amt] = ps[b];
      end
      r.aln_prod[i*PA +: PA] = pr;
    end
    cs  = '0;
    cs[CA-1 -: SW+1] = s.c;
    cr  = '0;
    r.stc = 1'b0;
    amt = int'(s.sc);
    for (int b = 0; b < int'(CA); b++) begin
      if (b < amt) r.stc = r.stc | cs[b];
      else         cr[b-amt] = cs[b];
    end
    r.alnc = cr;
    r.sign = {s.csign, s.psign};
    r.e    = s.e;
    return r;
  endfunction

  function automatic in_t zero_set();
    in_t s;
    s.prod = '0; s.psign = '0; s.sab = '0;
    s.c = '0; s.csign = 1'b0; s.sc = '0; s.e = '0;
    return s;
  endfunction

  task automatic drive(input in_t s);
    bus.prod_sig  = s.prod;
    bus.prod_sign = s.psign;
    bus.shamt_ab  = s.sab;
    bus.c_sig     = s.c;
    bus.c_sign    = s.csign;
    bus.shamt_c   = s.sc;
    bus.exp1      = s.e;
  endtask

  task automatic compare_out(input exp_t e, input string pfx);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s aln_prod[%0d]", pfx, i), 512'(bus.aln_prod[i*PA +: PA]), 512'(e.aln_prod[i*PA +: PA]));
    check({pfx, " sticky_prod"}, 512'(bus.sticky_prod), 512'(e.stp));
    check({pfx, " aln_c"},       512'(bus.aln_c),       512'(e.alnc));
    check({pfx, " sticky_c"},    512'(bus.sticky_c),    512'(e.stc));
    check({pfx, " sign_out"},    512'(bus.sign_out),    512'(e.sign));
    check({pfx, " exp_out"},     512'(bus.exp_out),     512'(e.e));
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, " out_valid"},   512'(bus.out_valid),   512'(0));
    check({pfx, " aln_prod"},    512'(bus.aln_prod),    512'(0));
    check({pfx, " sticky_prod"}, 512'(bus.sticky_prod), 512'(0));
    check({pfx, " aln_c"},       512'(bus.aln_c),       512'(0));
    check({pfx, " sticky_c"},    512'(bus.sticky_c),    512'(0));
    check({pfx, " sign_out"},    512'(bus.sign_out),    512'(0));
    check({pfx, " exp_out"},     512'(bus.exp_out),     512'(0));
  endtask

  // Present a set, wait (bounded) for in_ready, take the accepting edge.
  task automatic accept_set(input in_t s, input string pfx);
    bit ok = 1'b0;
    drive(s);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({pfx, " in_ready_wait"}, 512'(ok), 512'(1));
    @(posedge clk);
    if (ok) sb.push_back(model(s));
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge: out_valid must appear exactly 10 edges later.
  task automatic await_out(input string pfx, output exp_t e);
    int lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({pfx, " latency"}, 512'(lat), 512'(10));
    e = zero_set_exp();
    if (sb.size() == 0) begin
      check({pfx, " scoreboard_nonempty"}, 512'(0), 512'(1));
    end else begin
      e = sb.pop_front();
      if (bus.out_valid) compare_out(e, pfx);
    end
  endtask

  function automatic exp_t zero_set_exp();
    exp_t e;
    e.aln_prod = '0; e.stp = '0; e.alnc = '0; e.stc = 1'b0; e.sign = '0; e.e = '0;
    return e;
  endfunction

  task automatic run_set(input in_t s, input string pfx);
    exp_t e;
    accept_set(s, pfx);
    await_out(pfx, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t  s, b;
    exp_t e;

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    drive(zero_set());

    // Reset state, with in_valid asserted: in_ready must stay low under rst
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 512'(bus.in_ready), 512'(0));
    check_zero_outputs("rst");
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("idle in_ready", 512'(bus.in_ready), 512'(1));

    // Unity alignment
    s = zero_set();
    for (int i = 0; i < 9; i++) s.prod[i*PW +: PW] = 48'h8000_0000_0000;
    s.c = 24'h80_0000; s.psign = 9'h15A; s.csign = 1'b1; s.e = 8'h7F;
    run_set(s, "unity");
    check("unity aln_prod0_const", 512'(bus.aln_prod[PA-1:0]), 512'(50'h2_0000_0000_0000));
    check("unity aln_c_const", 512'(bus.aln_c), 512'(78'h80_0000) << 54);

    // Shift by 3 with bits lost to sticky
    s = zero_set();
    s.sab[1*AW +: AW] = 9'd3; s.prod[1*PW +: PW] = 48'hF; s.e = 8'h01;
    run_set(s, "shift3");

    // Product saturation, sticky set and clear
    s = zero_set();
    s.sab[4*AW +: AW] = 9'd60; s.prod[4*PW +: PW] = 48'h1;
    run_set(s, "psat1");
    s.prod[4*PW +: PW] = 48'h0;
    run_set(s, "psat0");

    // Product shift exactly at field width and one below
    s = zero_set();
    s.sab[8*AW +: AW] = 9'd50; s.prod[8*PW +: PW] = 48'hFFFF_FFFF_FFFF;
    s.sab[0*AW +: AW] = 9'd49; s.prod[0*PW +: PW] = 48'h8000_0000_0001;
    run_set(s, "pedge");

    // Addend saturation and exact-fit shift
    s = zero_set();
    s.c = 24'h80_0000; s.sc = 9'd78;
    run_set(s, "csat");
    s.sc = 9'd54;
    run_set(s, "c54");
    s.sc = 9'd511; s.c = 24'hFF_FFFF;
    run_set(s, "cmax");

    // Random sets, issued back-to-back out of DONE
    for (int k = 0; k < 6; k++) begin
      s = zero_set();
      for (int i = 0; i < 9; i++) begin
        s.prod[i*PW +: PW] = {16'($urandom), $urandom};
        s.sab[i*AW +: AW]  = 9'($urandom_range(0, 90));
      end
      s.psign = 9'($urandom);
      s.c     = 24'($urandom) | 24'h80_0000;
      s.csign = 1'($urandom);
      s.sc    = 9'($urandom_range(0, 100));
      s.e     = 8'($urandom);
      run_set(s, $sformatf("rand%0d", k));
    end

    // Backpressure in DONE with a new set waiting
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    s = zero_set();
    s.prod[2*PW +: PW] = 48'hABCD_1234_5678; s.sab[2*AW +: AW] = 9'd7;
    s.c = 24'hC0_0001; s.sc = 9'd20; s.psign = 9'h0F0; s.e = 8'hA5;
    accept_set(s, "bp");
    await_out("bp", e);
    b = zero_set();
    b.prod[6*PW +: PW] = 48'h1234_5678_9ABC; b.sab[6*AW +: AW] = 9'd12;
    b.c = 24'h9F_FFFF; b.sc = 9'd60; b.csign = 1'b1; b.e = 8'h3C;
    drive(b);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out_valid", n), 512'(bus.out_valid), 512'(1));
      check($sformatf("bp hold%0d in_ready", n),  512'(bus.in_ready),  512'(0));
      compare_out(e, $sformatf("bp hold%0d", n));
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 512'(bus.in_ready), 512'(1));
    @(posedge clk);
    sb.push_back(model(b));
    #1;
    bus.in_valid = 1'b0;
    check("bp b2b out_valid_low", 512'(bus.out_valid), 512'(0));
    await_out("bp2", e);

    // Reset while in SHIFT with idx=4
    @(posedge clk); #1;
    s = zero_set();
    s.prod[0*PW +: PW] = 48'hFFFF; s.sab[0*AW +: AW] = 9'd1; s.e = 8'h55; s.psign = 9'h1FF;
    accept_set(s, "abort");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("abort");
    check("abort in_ready", 512'(bus.in_ready), 512'(1));
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      check($sformatf("abort quiet%0d", n), 512'(bus.out_valid), 512'(0));
    end

    // Fresh accept after abort
    s = zero_set();
    s.prod[3*PW +: PW] = 48'h7; s.sab[3*AW +: AW] = 9'd2;
    s.c = 24'hAA_AAAA; s.sc = 9'd70; s.e = 8'hEE;
    run_set(s, "fresh");

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
